// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage memory access unit: FSM states,
// request classification kinds and default memory geometry.
package mem_pkg;

  localparam int SIZE_DM_DEF = 128;
  localparam int LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    KIND_LOAD  = 2'd0,
    KIND_STORE = 2'd1,
    KIND_PASS  = 2'd2,
    KIND_ERR   = 2'd3
  } kind_t;

endpackage

// File: rtl/mau_req_check.sv
// Combinational request classifier: decides load/store/pass/err and
// extracts the word index from a byte address.
module mau_req_check
  import mem_pkg::*;
#(
  parameter int SIZE_DM = SIZE_DM_DEF,
  parameter int IDX_W   = $clog2(SIZE_DM)
) (
  input  logic              req_read,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  output kind_t             kind,
  output logic [IDX_W-1:0]  word_idx
);

  logic mem_op;
  logic misaligned;
  logic out_of_range;

  always_comb begin
    mem_op       = req_read | req_write;
    misaligned   = (req_addr[1:0] != 2'b00);
    out_of_range = ({2'b00, req_addr[31:2]} >= 32'(SIZE_DM));
    kind         = KIND_PASS;
    if (req_read && req_write) begin
      kind = KIND_ERR;
    end else if (!mem_op) begin
      kind = KIND_PASS;
    end else if (misaligned || out_of_range) begin
      kind = KIND_ERR;
    end else if (req_read) begin
      kind = KIND_LOAD;
    end else begin
      kind = KIND_STORE;
    end
  end

  assign word_idx = req_addr[IDX_W+1:2];

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: accepts one request per handshake, drives the
// word-addressed data memory for LATENCY cycles and returns a response strobe.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int SIZE_DM = SIZE_DM_DEF,
  parameter int LATENCY = LATENCY_DEF,
  parameter int IDX_W   = $clog2(SIZE_DM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_alu,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              stall,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic               is_load_reg;
  logic [IDX_W-1:0]   mem_addr_reg;
  logic [31:0]        mem_wdata_reg;
  logic               mem_write_reg;
  logic [31:0]        resp_data_reg;
  logic               resp_err_reg;

  kind_t              req_kind;
  logic [IDX_W-1:0]   req_idx;
  logic               accept;
  logic               is_mem_op;
  logic               wait_done;

  mau_req_check #(
    .SIZE_DM (SIZE_DM),
    .IDX_W   (IDX_W)
  ) u_req_check (
    .req_read  (req_read),
    .req_write (req_write),
    .req_addr  (req_addr),
    .kind      (req_kind),
    .word_idx  (req_idx)
  );

  assign accept    = req_valid && (state_reg == IDLE);
  assign is_mem_op = (req_kind == KIND_LOAD) || (req_kind == KIND_STORE);
  assign wait_done = (state_reg == WAIT) && (cnt_reg == '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = is_mem_op ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      is_load_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_write_reg <= 1'b0;
      resp_data_reg <= '0;
      resp_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      // The write strobe lives only for the first WAIT cycle of a store.
      mem_write_reg <= accept && (req_kind == KIND_STORE);
      if (accept) begin
        cnt_reg <= CNT_W'(LATENCY - 1);
      end else if ((state_reg == WAIT) && (cnt_reg != '0)) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (accept && is_mem_op) begin
        mem_addr_reg  <= req_idx;
        mem_wdata_reg <= req_wdata;
        is_load_reg   <= (req_kind == KIND_LOAD);
      end
      if (accept && !is_mem_op) begin
        resp_data_reg <= (req_kind == KIND_ERR) ? 32'd0 : req_alu;
        resp_err_reg  <= (req_kind == KIND_ERR);
      end else if (wait_done) begin
        resp_data_reg <= is_load_reg ? mem_rdata : 32'd0;
        resp_err_reg  <= 1'b0;
      end
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign stall      = !req_ready;
  assign resp_valid = (state_reg == RESP);
  assign resp_data  = resp_data_reg;
  assign resp_err   = resp_err_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign mem_write  = mem_write_reg;
  assign mem_read   = (state_reg == WAIT) && is_load_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: two units (LATENCY=2 and LATENCY=1) with behavioural
// memories, checked against a transaction-level reference model.
module tb_mem_access_unit;

  localparam int SIZE_DM = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_read, req_write;
  logic [31:0] req_addr, req_wdata, req_alu;
  logic        sel;

  logic        rdy0, rv0, re0, stl0, mw0, mr0;
  logic [31:0] rd0, mwd0, mrd0;
  logic [6:0]  ma0;
  logic        rdy1, rv1, re1, stl1, mw1, mr1;
  logic [31:0] rd1, mwd1, mrd1;
  logic [6:0]  ma1;

  logic        o_ready, o_rv, o_re, o_stall, o_mw, o_mr;
  logic [31:0] o_rd, o_mwd;
  logic [6:0]  o_ma;

  bit   [31:0] mem0 [SIZE_DM];
  bit   [31:0] mem1 [SIZE_DM];
  bit          wv0  [SIZE_DM];
  bit          wv1  [SIZE_DM];
  logic [31:0] ref_mem [2][SIZE_DM];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] seed(input int d, input int i);
    if (d == 1 && i == 0) return 32'h55;
    return (32'(i) * 32'h9E3779B9) ^ (32'(d) << 16);
  endfunction

  assign mrd0 = wv0[ma0] ? mem0[ma0] : seed(0, int'(ma0));
  assign mrd1 = wv1[ma1] ? mem1[ma1] : seed(1, int'(ma1));

  always @(posedge clk) begin
    if (mw0) begin mem0[ma0] <= mwd0; wv0[ma0] <= 1'b1; end
    if (mw1) begin mem1[ma1] <= mwd1; wv1[ma1] <= 1'b1; end
  end

  assign o_ready = sel ? rdy1 : rdy0;
  assign o_rv    = sel ? rv1  : rv0;
  assign o_re    = sel ? re1  : re0;
  assign o_stall = sel ? stl1 : stl0;
  assign o_mw    = sel ? mw1  : mw0;
  assign o_mr    = sel ? mr1  : mr0;
  assign o_rd    = sel ? rd1  : rd0;
  assign o_mwd   = sel ? mwd1 : mwd0;
  assign o_ma    = sel ? ma1  : ma0;

  mem_access_unit #(.SIZE_DM(SIZE_DM), .LATENCY(2)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel), .req_ready(rdy0),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_alu(req_alu), .resp_valid(rv0), .resp_data(rd0),
    .resp_err(re0), .stall(stl0), .mem_addr(ma0), .mem_wdata(mwd0),
    .mem_write(mw0), .mem_read(mr0), .mem_rdata(mrd0)
  );

  mem_access_unit #(.SIZE_DM(SIZE_DM), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel), .req_ready(rdy1),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_alu(req_alu), .resp_valid(rv1), .resp_data(rd1),
    .resp_err(re1), .stall(stl1), .mem_addr(ma1), .mem_wdata(mwd1),
    .mem_write(mw1), .mem_read(mr1), .mem_rdata(mrd1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"},  32'(rdy0), 32'd1);
    chk({tag, "_stall"},  32'(stl0), 32'd0);
    chk({tag, "_rvalid"}, 32'(rv0),  32'd0);
    chk({tag, "_rerr"},   32'(re0),  32'd0);
    chk({tag, "_rdata"},  rd0,       32'd0);
    chk({tag, "_maddr"},  32'(ma0),  32'd0);
    chk({tag, "_mwdata"}, mwd0,      32'd0);
    chk({tag, "_mwrite"}, 32'(mw0),  32'd0);
    chk({tag, "_mread"},  32'(mr0),  32'd0);
  endtask

  // One complete transaction on the unit picked by sel, checked end to end.
  task automatic do_req(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] alu);
    int          lat_cfg, exp_lat, idx, lat, nwr, nrd, d;
    bit          err, pass, seen;
    logic [31:0] exp_data, got_data;
    logic        got_err;
    d        = sel ? 1 : 0;
    lat_cfg  = sel ? 1 : 2;
    err      = (r && w) || ((r || w) && ((a[1:0] != 2'b00) || ((a >> 2) >= 32'(SIZE_DM))));
    pass     = !r && !w;
    idx      = int'(a[8:2]);
    if (err)       exp_data = 32'd0;
    else if (pass) exp_data = alu;
    else if (w)    exp_data = 32'd0;
    else           exp_data = ref_mem[d][idx];
    exp_lat  = (err || pass) ? 1 : lat_cfg + 1;

    @(negedge clk);
    req_read = r; req_write = w; req_addr = a; req_wdata = wd; req_alu = alu;
    req_valid = 1'b1;
    chk("ready_before", 32'(o_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; nwr = 0; nrd = 0; seen = 0; got_data = 32'hx; got_err = 1'bx;
    for (int k = 1; k <= 10 && !seen; k++) begin
      if (k > 1) @(negedge clk);
      if (o_mw) begin
        nwr++;
        chk("wr_addr", 32'(o_ma), 32'(idx));
        chk("wr_data", o_mwd, wd);
      end
      if (o_mr) begin
        nrd++;
        chk("rd_addr", 32'(o_ma), 32'(idx));
      end
      if (o_rv) begin
        seen = 1; lat = k; got_data = o_rd; got_err = o_re;
      end
    end
    chk("latency",   32'(lat), 32'(exp_lat));
    chk("resp_data", got_data, exp_data);
    chk("resp_err",  32'(got_err), 32'(err));
    chk("n_writes",  32'(nwr), (w && !err) ? 32'd1 : 32'd0);
    chk("n_reads",   32'(nrd), (r && !err) ? 32'(lat_cfg) : 32'd0);
    if (w && !err) ref_mem[d][idx] = wd;
    $display("txn unit=%0d rd=%0d wr=%0d addr=%h wdata=%h alu=%h -> lat=%0d data=%h err=%0d",
             d, r, w, a, wd, alu, lat, got_data, got_err);
    @(negedge clk);
    chk("rv_after",   32'(o_rv), 32'd0);
    chk("ready_after", 32'(o_ready), 32'd1);
    chk("data_hold",  o_rd, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sa [3];
    logic [31:0] sd [3];
    int          acc_cyc [3];
    int          n_acc, last, nwr, nresp;
    bit          pend, exp_rdy;
    logic [31:0] ra;
    int          mode;

    for (int i = 0; i < SIZE_DM; i++) begin
      ref_mem[0][i] = seed(0, i);
      ref_mem[1][i] = seed(1, i);
    end
    sel = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_alu = '0;
    rst_n = 1'b0;
    #23;
    check_reset_vals("reset");
    chk("reset_ready_u1", 32'(rdy1), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Store then load back the same word.
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
    // Pass-through.
    do_req(1'b0, 1'b0, 32'h0, 32'h0, 32'h1234);
    // Illegal requests: misaligned, out of range, read+write.
    do_req(1'b1, 1'b0, 32'h13, 32'h0, 32'h77);
    do_req(1'b1, 1'b0, 32'h200, 32'h0, 32'h77);
    do_req(1'b1, 1'b1, 32'h10, 32'h1, 32'h77);
    // Highest legal word.
    do_req(1'b0, 1'b1, 32'h1FC, 32'hA5A55A5A, 32'h0);
    do_req(1'b1, 1'b0, 32'h1FC, 32'h0, 32'h0);

    // Back-to-back stores with req_valid held high.
    for (int i = 0; i < 3; i++) begin
      sa[i] = 32'($urandom_range(0, SIZE_DM - 1)) << 2;
      sd[i] = $urandom;
    end
    @(negedge clk);
    req_read = 1'b0; req_write = 1'b1; req_addr = sa[0]; req_wdata = sd[0];
    req_valid = 1'b1;
    n_acc = 0; pend = 0; last = -100; nwr = 0; nresp = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (pend) begin
        pend = 0;
        n_acc++;
        if (n_acc < 3) begin
          req_addr = sa[n_acc]; req_wdata = sd[n_acc];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (mw0) nwr++;
      if (rv0) nresp++;
      exp_rdy = (cyc - last) >= 4;
      chk("b2b_stall_vs_ready", 32'(stl0), 32'(!rdy0));
      chk("b2b_ready", 32'(rdy0), 32'(exp_rdy));
      if (rdy0 && req_valid) begin
        pend = 1; acc_cyc[n_acc] = cyc; last = cyc;
      end
    end
    chk("b2b_accepts", 32'(n_acc), 32'd3);
    chk("b2b_space01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
    chk("b2b_space12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
    chk("b2b_writes",  32'(nwr), 32'd3);
    chk("b2b_resps",   32'(nresp), 32'd3);
    for (int i = 0; i < 3; i++) begin
      ref_mem[0][sa[i] >> 2] = sd[i];
      $display("txn unit=0 b2b store addr=%h wdata=%h accept_cycle=%0d", sa[i], sd[i], acc_cyc[i]);
    end
    do_req(1'b1, 1'b0, sa[2], 32'h0, 32'h0);
    do_req(1'b1, 1'b0, sa[0], 32'h0, 32'h0);

    // Reset asserted in the middle of a load's WAIT.
    @(negedge clk);
    req_read = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst_in_wait", 32'(mr0), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("postrst_rv", 32'(rv0), 32'd0);
      chk("postrst_ready", 32'(rdy0), 32'd1);
    end
    $display("txn unit=0 load addr=00000020 aborted by reset");

    // LATENCY=1 unit: load word 0.
    sel = 1'b1;
    do_req(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    do_req(1'b0, 1'b1, 32'h8, 32'h0BADF00D, 32'h0);
    do_req(1'b1, 1'b0, 32'h8, 32'h0, 32'h0);

    // Randomized mix on both units.
    for (int n = 0; n < 40; n++) begin
      sel  = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 5);
      case (mode)
        0, 1, 2: ra = 32'($urandom_range(0, SIZE_DM - 1)) << 2;
        3:       ra = (32'($urandom_range(0, SIZE_DM - 1)) << 2) | 32'($urandom_range(1, 3));
        default: ra = 32'($urandom_range(SIZE_DM, 1 << 20)) << 2;
      endcase
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage initiator for the word-addressed data memory. It accepts one load/store/pass-through request per handshake from the EX/MEM boundary and converts the byte address to a word index. It drives the memory's addr/wData/MemWrite/MemRead side for a fixed number of wait cycles, returns load data or the ALU result on a response strobe, and stalls the pipeline while busy.

Parameters:
SIZE_DM, 128, data memory depth in 32-bit words; legal word index range is 0..SIZE_DM-1
LATENCY, 2, memory wait cycles per load/store, >=1
IDX_W, $clog2(SIZE_DM), width of mem_addr word index

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept; high only in IDLE
req_read  input  1  load request (MemRead)
req_write  input  1  store request (MemWrite)
req_addr  input  32  byte address
req_wdata  input  32  store data
req_alu  input  32  ALU result, returned for non-memory requests
resp_valid  output  1  one-cycle response strobe
resp_data  output  32  load data, or req_alu for pass-through, or 0 on error
resp_err  output  1  qualifies resp_valid; request was illegal
stall  output  1  pipeline hold, equal to !req_ready
mem_addr  output  IDX_W  word index to memory
mem_wdata  output  32  store data to memory
mem_write  output  1  memory write enable
mem_read  output  1  memory read enable
mem_rdata  input  32  memory read data, combinational from mem_addr

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n. All state is cleared immediately on assertion.
- Reset values: state=IDLE, counter=0, req_ready=1, stall=0, resp_valid=0, resp_err=0, resp_data=0, mem_addr=0, mem_wdata=0, mem_write=0, mem_read=0.
- FSM states: IDLE, WAIT, RESP.
- Accept: req_valid && req_ready at a rising edge.
- Classification at accept:
  - err if req_read && req_write, or if a memory op has req_addr[1:0]!=0, or if a memory op has req_addr[31:2] >= SIZE_DM.
  - pass-through if neither read nor write.
  - otherwise load or store.
- Err or pass-through: IDLE -> RESP directly. The memory is never touched. resp_data = 0 on err, req_alu on pass-through. resp_err is set on err only.
- Load or store: IDLE -> WAIT.
  - Counter loads LATENCY-1.
  - mem_addr is registered as req_addr[IDX_W+1:2]; mem_wdata is registered as req_wdata.
  - Both are held for all LATENCY WAIT cycles.
  - mem_read is high for all WAIT cycles of a load.
  - mem_write is high only in the first WAIT cycle of a store, so exactly one write edge occurs.
- WAIT: the counter decrements each cycle. When counter==0, go to RESP.
  - Load: capture mem_rdata into resp_data on that same edge.
  - Store: resp_data = 0.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. mem_read and mem_write are 0.
- Timing for an accept at edge T:
  - Memory op: resp_valid in cycle T+LATENCY+1; next accept possible at edge T+LATENCY+2.
  - Pass-through or err: resp_valid in cycle T+1; next accept at T+2.
- req_ready and stall are decoded combinationally from state. Inputs are ignored outside IDLE.
- resp_data holds its value after RESP until the next response overwrites it.
- Reset mid-WAIT: the request is discarded and no response is produced. A store interrupted during its write cycle has an undefined memory effect.
- Counter width is $clog2(LATENCY+1); no wrap occurs because it reloads on every accept.

Decomposition:
- Shared package mem_pkg: state encoding (IDLE/WAIT/RESP), default SIZE_DM and LATENCY constants, request-kind constants (LOAD/STORE/PASS/ERR).
- One combinational sub-module, mau_req_check: takes req_read, req_write and req_addr; outputs kind and word index. Legality rules live here in one place.

Test Plan:
1. Reset release, then req_valid=1, req_write=1, req_addr=0x10, req_wdata=0xDEADBEEF -> mem_addr=4 and mem_write=1 for exactly one cycle; resp_valid 3 cycles after accept with resp_err=0. A following load of 0x10 returns resp_data=0xDEADBEEF.
2. Pass-through request with req_alu=0x1234 and both read/write low -> resp_valid the next cycle, resp_data=0x1234, mem_read=mem_write=0 throughout.
3. Load at 0x13, then a load at 0x200 (word 128 with SIZE_DM=128), then a request with req_read=req_write=1 -> each gives resp_err=1, resp_data=0, no memory strobes, 1-cycle latency.
4. Back-to-back req_valid held high with 3 stores -> stall=1 and req_ready=0 during WAIT/RESP; accepts are spaced exactly LATENCY+2=4 cycles apart; 3 write pulses total.
5. Assert rst_n=0 in the middle of a load's WAIT -> outputs return to reset values immediately with no resp_valid; after release, req_ready=1 the next cycle.
6. Rebuild with LATENCY=1: a load at 0x0 with memory word 0=0x55 -> mem_read high for 1 cycle; resp_valid 2 cycles after accept with resp_data=0x55.
